// File: rtl/dmux_4way_pkg.sv
// Shared constants for the registered 1-to-4 demultiplexer: select encodings
// and the output reset value.
package dmux_4way_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

    // Replicated to WIDTH at the point of use so outputs reset to all-zeros.
    localparam logic RST_BIT = 1'b0;

endpackage

// File: rtl/dmux_4way_if.sv
// Data/select bus of the 4-way demultiplexer; the master drives data and
// select, the slave returns the four routed outputs.
interface dmux_4way_if
    import dmux_4way_pkg::*;
#(
    parameter int WIDTH = 1
) ();

    logic [WIDTH-1:0] in_i;
    sel_t             sel_i;
    logic [WIDTH-1:0] a_o;
    logic [WIDTH-1:0] b_o;
    logic [WIDTH-1:0] c_o;
    logic [WIDTH-1:0] d_o;

    modport master (
        output in_i,
        output sel_i,
        input  a_o,
        input  b_o,
        input  c_o,
        input  d_o
    );

    modport slave (
        input  in_i,
        input  sel_i,
        output a_o,
        output b_o,
        output c_o,
        output d_o
    );

endinterface

// File: rtl/dmux_4way_2way.sv
// Combinational 1-to-2 demultiplexer: the unselected output is held at zero.
module dmux_2way #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] in,
    input  logic             sel,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b
);

    // Route in to a when sel is low, to b otherwise.
    always_comb begin
        a = {WIDTH{1'b0}};
        b = {WIDTH{1'b0}};
        if (sel == 1'b0) begin
            a = in;
        end else begin
            b = in;
        end
    end

endmodule

// File: rtl/dmux_4way.sv
// Registered 1-to-4 demultiplexer built from a two-level tree of 2-way
// demultiplexers, with asynchronously cleared output registers.
module dmux_4way
    import dmux_4way_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    dmux_4way_if.slave   bus
);

    sel_t             sel_s;
    logic [WIDTH-1:0] lo_s;
    logic [WIDTH-1:0] hi_s;
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH-1:0] c_s;
    logic [WIDTH-1:0] d_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] c_r;
    logic [WIDTH-1:0] d_r;

    assign sel_s = bus.sel_i;

    // sel[1] picks the pair, sel[0] picks the slot inside that pair.
    dmux_2way #(.WIDTH(WIDTH)) u_pair (
        .in  (bus.in_i),
        .sel (sel_s[1]),
        .a   (lo_s),
        .b   (hi_s)
    );

    dmux_2way #(.WIDTH(WIDTH)) u_lo (
        .in  (lo_s),
        .sel (sel_s[0]),
        .a   (a_s),
        .b   (b_s)
    );

    dmux_2way #(.WIDTH(WIDTH)) u_hi (
        .in  (hi_s),
        .sel (sel_s[0]),
        .a   (c_s),
        .b   (d_s)
    );

    // Capture the decoded slots; reset clears all four without a clock.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_r <= {WIDTH{RST_BIT}};
            b_r <= {WIDTH{RST_BIT}};
            c_r <= {WIDTH{RST_BIT}};
            d_r <= {WIDTH{RST_BIT}};
        end else begin
            a_r <= a_s;
            b_r <= b_s;
            c_r <= c_s;
            d_r <= d_s;
        end
    end

    assign bus.a_o = a_r;
    assign bus.b_o = b_r;
    assign bus.c_o = c_r;
    assign bus.d_o = d_r;

endmodule

// File: tb/tb_dmux_4way.sv
// Self-checking bench for dmux_4way: a 1-bit and a 16-bit instance share clock,
// reset and select, and are compared against a slot-array reference model.
module tb_dmux_4way;
    import dmux_4way_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic        exp1  [4];
    logic [15:0] exp16 [4];
    logic [15:0] last_in16;

    dmux_4way_if #(.WIDTH(1))  bus1 ();
    dmux_4way_if #(.WIDTH(16)) bus16 ();

    dmux_4way #(.WIDTH(1)) dut1 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus1.slave)
    );

    dmux_4way #(.WIDTH(16)) dut16 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        int nz;
        check("w1_a", {15'd0, bus1.a_o}, {15'd0, exp1[0]});
        check("w1_b", {15'd0, bus1.b_o}, {15'd0, exp1[1]});
        check("w1_c", {15'd0, bus1.c_o}, {15'd0, exp1[2]});
        check("w1_d", {15'd0, bus1.d_o}, {15'd0, exp1[3]});
        check("w16_a", bus16.a_o, exp16[0]);
        check("w16_b", bus16.b_o, exp16[1]);
        check("w16_c", bus16.c_o, exp16[2]);
        check("w16_d", bus16.d_o, exp16[3]);
        nz = 0;
        if (bus16.a_o != 16'd0) nz++;
        if (bus16.b_o != 16'd0) nz++;
        if (bus16.c_o != 16'd0) nz++;
        if (bus16.d_o != 16'd0) nz++;
        check("w16_onehot", (nz <= 1) ? 16'd1 : 16'd0, 16'd1);
        check("w16_or", bus16.a_o | bus16.b_o | bus16.c_o | bus16.d_o, last_in16);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_w1"}, {12'd0, bus1.a_o, bus1.b_o, bus1.c_o, bus1.d_o}, 16'd0);
        check({tag, "_w16"}, bus16.a_o | bus16.b_o | bus16.c_o | bus16.d_o, 16'd0);
    endtask

    // Drive inputs, clock once, update the slot model, then compare.
    task automatic cyc(input logic in1, input logic [15:0] in16, input int sel);
        bus1.in_i   = in1;
        bus16.in_i  = in16;
        bus1.sel_i  = sel[1:0];
        bus16.sel_i = sel[1:0];
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            exp1[k]  = (k == sel) ? in1  : 1'b0;
            exp16[k] = (k == sel) ? in16 : 16'd0;
        end
        last_in16 = in16;
        check_model();
    endtask

    initial begin
        int sel;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        bus1.in_i   = 1'b1;
        bus16.in_i  = 16'hFFFF;
        bus1.sel_i  = SEL_D;
        bus16.sel_i = SEL_D;

        // Asynchronous reset before any clock edge
        #3 rst_n = 1'b0;
        #1 check_zero("rst_async");
        @(posedge clk); #1 check_zero("rst_hold1");
        @(posedge clk); #1 check_zero("rst_hold2");
        @(negedge clk) rst_n = 1'b1;
        cyc(1'b1, 16'hFFFF, 3);

        for (int s = 0; s < 4; s++) cyc(1'b0, 16'h0000, s);
        for (int s = 0; s < 4; s++) cyc(1'b1, 16'h8001, s);

        // Select change between edges must not show until the next edge
        cyc(1'b1, 16'h1234, 0);
        bus1.sel_i  = SEL_C;
        bus16.sel_i = SEL_C;
        #3 check_model();
        cyc(1'b1, 16'h1234, 2);

        cyc(1'b1, 16'hA5C3, 1);
        check("wide_b", bus16.b_o, 16'hA5C3);

        // Mid-run reset while d holds data
        cyc(1'b1, 16'h5A5A, 3);
        rst_n = 1'b0;
        #1 check_zero("midrst");
        @(negedge clk) check_zero("midrst_low");
        rst_n = 1'b1;
        #1 check_zero("midrst_released");
        cyc(1'b1, 16'h5A5A, 3);

        for (int i = 0; i < 1000; i++) begin
            sel = int'($urandom_range(3, 0));
            if ($urandom_range(7, 0) == 0) cyc(1'b0, 16'h0000, sel);
            else cyc(1'($urandom), 16'($urandom), sel);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
